// File: rtl/rx_fifo.sv
// Receive message FIFO between the acceptance filter and the register interface.
// First-word-fall-through head, sticky over/underflow flags; RX_FIFO_WATERMARK_EN adds a level watermark.
module rx_fifo #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 128
) (
    input  logic                     i_sys_clk,
    input  logic                     i_reset,
    input  logic                     i_rx_w_en,
    input  logic [DATA_W-1:0]        i_rx_w_data,
    output logic                     o_rx_full,
    input  logic                     i_rx_r_en,
    output logic [DATA_W-1:0]        o_rx_r_data,
    output logic                     o_rx_empty,
    output logic [$clog2(DEPTH):0]   o_rx_count,
    output logic                     o_rx_ovfl,
    output logic                     o_rx_udfl,
`ifdef RX_FIFO_WATERMARK_EN
    input  logic [$clog2(DEPTH):0]   i_wmark_level,
    output logic                     o_rx_wmark,
`endif
    input  logic                     i_clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [AW:0]       count_nxt;
    logic              wr;
    logic              rd;

    // Flags come only from registered pointers, never from the strobes.
    assign o_rx_empty  = (wptr == rptr);
    assign o_rx_full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign o_rx_r_data = mem[rptr[AW-1:0]];

    assign wr = i_rx_w_en && !o_rx_full;
    assign rd = i_rx_r_en && !o_rx_empty;

    always_comb begin
        count_nxt = o_rx_count;
        unique case ({wr, rd})
            2'b10:   count_nxt = o_rx_count + ONE;
            2'b01:   count_nxt = o_rx_count - ONE;
            default: count_nxt = o_rx_count;
        endcase
    end

    // Storage is intentionally not reset.
    always_ff @(posedge i_sys_clk) begin
        if (wr) begin
            mem[wptr[AW-1:0]] <= i_rx_w_data;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset) begin
        if (!i_reset) begin
            wptr       <= '0;
            rptr       <= '0;
            o_rx_count <= '0;
            o_rx_ovfl  <= 1'b0;
            o_rx_udfl  <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + ONE;
            if (rd) rptr <= rptr + ONE;
            o_rx_count <= count_nxt;
            // A new offence wins over a clear arriving in the same cycle.
            if (i_rx_w_en && o_rx_full) o_rx_ovfl <= 1'b1;
            else if (i_clr_flags)       o_rx_ovfl <= 1'b0;
            if (i_rx_r_en && o_rx_empty) o_rx_udfl <= 1'b1;
            else if (i_clr_flags)        o_rx_udfl <= 1'b0;
        end
    end

`ifdef RX_FIFO_WATERMARK_EN
    // Evaluated on the post-update count so the flag lines up with o_rx_count.
    always_ff @(posedge i_sys_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_rx_wmark <= 1'b0;
        end else begin
            o_rx_wmark <= (i_wmark_level != '0) && (count_nxt >= i_wmark_level);
        end
    end
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_rx_fifo;

    localparam int DEPTH  = 64;
    localparam int DATA_W = 128;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              w_en = 1'b0;
    logic [DATA_W-1:0] w_data = '0;
    logic              r_en = 1'b0;
    logic              clr = 1'b0;
    logic              o_full;
    logic              o_empty;
    logic [DATA_W-1:0] o_rdata;
    logic [CW-1:0]     o_count;
    logic              o_ovfl;
    logic              o_udfl;
`ifdef RX_FIFO_WATERMARK_EN
    logic [CW-1:0]     wlevel = '0;
    logic              o_wmark;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q[$];
    logic              m_ovfl = 1'b0;
    logic              m_udfl = 1'b0;
    logic              m_wmark = 1'b0;

    localparam logic [DATA_W-1:0] A1 = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAA1;
    localparam logic [DATA_W-1:0] A2 = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAA2;
    localparam logic [DATA_W-1:0] A3 = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAA3;

    rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .i_sys_clk    (clk),
        .i_reset      (rst_n),
        .i_rx_w_en    (w_en),
        .i_rx_w_data  (w_data),
        .o_rx_full    (o_full),
        .i_rx_r_en    (r_en),
        .o_rx_r_data  (o_rdata),
        .o_rx_empty   (o_empty),
        .o_rx_count   (o_count),
        .o_rx_ovfl    (o_ovfl),
        .o_rx_udfl    (o_udfl),
`ifdef RX_FIFO_WATERMARK_EN
        .i_wmark_level(wlevel),
        .o_rx_wmark   (o_wmark),
`endif
        .i_clr_flags  (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of stored messages plus the two sticky flags.
    always @(posedge clk or negedge rst_n) begin
        int n;
        if (!rst_n) begin
            q.delete();
            m_ovfl  = 1'b0;
            m_udfl  = 1'b0;
            m_wmark = 1'b0;
        end else begin
            n = q.size();
            if (w_en && n == DEPTH)   m_ovfl = 1'b1;
            else if (clr)             m_ovfl = 1'b0;
            if (r_en && n == 0)       m_udfl = 1'b1;
            else if (clr)             m_udfl = 1'b0;
            if (r_en && n > 0)        void'(q.pop_front());
            if (w_en && n < DEPTH)    q.push_back(w_data);
`ifdef RX_FIFO_WATERMARK_EN
            m_wmark = (wlevel != 0) && (q.size() >= int'(wlevel));
`endif
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            chk("count", DATA_W'(o_count), DATA_W'(q.size()));
            chk("empty", DATA_W'(o_empty), DATA_W'(q.size() == 0));
            chk("full",  DATA_W'(o_full),  DATA_W'(q.size() == DEPTH));
            chk("ovfl",  DATA_W'(o_ovfl),  DATA_W'(m_ovfl));
            chk("udfl",  DATA_W'(o_udfl),  DATA_W'(m_udfl));
            if (q.size() != 0) chk("rdata", o_rdata, q[0]);
`ifdef RX_FIFO_WATERMARK_EN
            chk("wmark", DATA_W'(o_wmark), DATA_W'(m_wmark));
`endif
        end
    end

    // One clock of stimulus; returns just after the edge has taken effect.
    task automatic cyc(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
        @(negedge clk);
        w_en = w; w_data = d; r_en = r; clr = c;
        @(posedge clk);
        #3;
        w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [DATA_W-1:0] head;
        logic [DATA_W-1:0] d;
        int pw, pr;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", DATA_W'(o_count), '0);
        chk("rst_empty", DATA_W'(o_empty), DATA_W'(1));
        chk("rst_full",  DATA_W'(o_full),  '0);
        chk("rst_ovfl",  DATA_W'(o_ovfl),  '0);
        chk("rst_udfl",  DATA_W'(o_udfl),  '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three ordered messages
        cyc(1, A1, 0, 0);
        cyc(1, A2, 0, 0);
        cyc(1, A3, 0, 0);
        chk("w3_count", DATA_W'(o_count), DATA_W'(3));
        chk("w3_empty", DATA_W'(o_empty), '0);
        chk("w3_head",  o_rdata, A1);
        cyc(0, '0, 1, 0);
        chk("r1_head", o_rdata, A2);
        cyc(0, '0, 1, 0);
        chk("r2_head", o_rdata, A3);
        cyc(0, '0, 1, 0);
        chk("r3_empty", DATA_W'(o_empty), DATA_W'(1));

        // Fill to full, then overflow
        head = rnd_word();
        cyc(1, head, 0, 0);
        for (int i = 1; i < DEPTH; i++) cyc(1, rnd_word(), 0, 0);
        chk("fill_full",  DATA_W'(o_full),  DATA_W'(1));
        chk("fill_count", DATA_W'(o_count), DATA_W'(DEPTH));
        cyc(1, 128'hBAD0BAD0, 0, 0);
        chk("ovf_flag",  DATA_W'(o_ovfl),  DATA_W'(1));
        chk("ovf_count", DATA_W'(o_count), DATA_W'(DEPTH));
        chk("ovf_head",  o_rdata, head);
        cyc(0, '0, 0, 1);
        chk("clr_ovfl", DATA_W'(o_ovfl), '0);

        // Read and write together while full
        cyc(1, 128'hDEAD, 1, 0);
        chk("rw_full_count", DATA_W'(o_count), DATA_W'(DEPTH-1));
        chk("rw_full_ovfl",  DATA_W'(o_ovfl),  DATA_W'(1));
        while (!o_empty) cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 1);

        // Underflow paths
        cyc(0, '0, 1, 0);
        chk("udf_flag",  DATA_W'(o_udfl),  DATA_W'(1));
        chk("udf_count", DATA_W'(o_count), '0);
        cyc(0, '0, 0, 1);
        d = rnd_word();
        cyc(1, d, 1, 0);
        chk("rw_empty_count", DATA_W'(o_count), DATA_W'(1));
        chk("rw_empty_udfl",  DATA_W'(o_udfl),  DATA_W'(1));
        chk("rw_empty_head",  o_rdata, d);
        cyc(0, '0, 1, 1);

        // Random mixed traffic with a mid-run reset
        for (int i = 0; i < 200; i++) begin
            pw = (i < 100) ? 70 : 30;
            pr = (i < 100) ? 40 : 70;
            cyc($urandom_range(99) < pw, rnd_word(), $urandom_range(99) < pr,
                $urandom_range(99) < 5);
            if (i == 150) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk("arst_count", DATA_W'(o_count), '0);
                chk("arst_empty", DATA_W'(o_empty), DATA_W'(1));
                chk("arst_full",  DATA_W'(o_full),  '0);
                @(negedge clk);
                rst_n = 1'b1;
                d = rnd_word();
                cyc(1, d, 0, 0);
                chk("post_rst_count", DATA_W'(o_count), DATA_W'(1));
                chk("post_rst_head",  o_rdata, d);
            end
        end
        while (!o_empty) cyc(0, '0, 1, 0);

`ifdef RX_FIFO_WATERMARK_EN
        cyc(0, '0, 0, 1);
        wlevel = CW'(4);
        for (int i = 0; i < 3; i++) cyc(1, rnd_word(), 0, 0);
        chk("wm_3", DATA_W'(o_wmark), '0);
        cyc(1, rnd_word(), 0, 0);
        chk("wm_4", DATA_W'(o_wmark), DATA_W'(1));
        cyc(0, '0, 1, 0);
        chk("wm_rd", DATA_W'(o_wmark), '0);
        wlevel = '0;
        for (int i = 0; i < 4; i++) cyc(1, rnd_word(), 0, 0);
        chk("wm_lvl0", DATA_W'(o_wmark), '0);
`endif

        repeat (2) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
